// File: rtl/alu_pkg.sv
// Shared op-codes and flag bundle for the RISC ALU datapath.
package alu_pkg;

  typedef logic [1:0] alu_op_t;

  localparam alu_op_t OP_ADD = 2'b00;
  localparam alu_op_t OP_SUB = 2'b01;
  localparam alu_op_t OP_AND = 2'b10;
  localparam alu_op_t OP_OR  = 2'b11;

  typedef struct packed {
    logic zero;
    logic carry;
    logic overflow;
    logic negative;
  } alu_flags_t;

endpackage

// File: rtl/alu_datapath.sv
// Combinational ALU core: result and status flags for one operation.
module alu_datapath
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  alu_op_t          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result_c,
  output alu_flags_t       flags_c
);

  localparam int unsigned MSB = WIDTH - 1;

  logic [WIDTH:0] sumExt;
  logic [WIDTH:0] diffExt;

  // Extended-width add/sub; the top bit is carry-out or borrow respectively.
  assign sumExt  = {1'b0, a} + {1'b0, b};
  assign diffExt = {1'b0, a} - {1'b0, b};

  always_comb begin
    result_c         = sumExt[WIDTH-1:0];
    flags_c          = '0;
    case (op)
      OP_SUB: begin
        result_c         = diffExt[WIDTH-1:0];
        flags_c.carry    = diffExt[WIDTH];
        flags_c.overflow = (a[MSB] != b[MSB]) && (diffExt[MSB] != a[MSB]);
      end
      OP_AND: result_c = a & b;
      OP_OR:  result_c = a | b;
      default: begin
        result_c         = sumExt[WIDTH-1:0];
        flags_c.carry    = sumExt[WIDTH];
        flags_c.overflow = (a[MSB] == b[MSB]) && (sumExt[MSB] != a[MSB]);
      end
    endcase
    flags_c.zero     = (result_c == '0);
    flags_c.negative = result_c[MSB];
  end

endmodule

// File: rtl/alu_unit.sv
// Registered ALU: one-cycle latency, result and flags held while idle.
module alu_unit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       ALU_Op,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  input  logic             in_valid,
  output logic [WIDTH-1:0] out,
  output logic             isZero,
  output logic             carry,
  output logic             overflow,
  output logic             negative,
  output logic             out_valid
);

  logic [WIDTH-1:0] result_c;
  alu_flags_t       flags_c;

  alu_datapath #(
    .WIDTH(WIDTH)
  ) uDatapath (
    .op      (alu_op_t'(ALU_Op)),
    .a       (inA),
    .b       (inB),
    .result_c(result_c),
    .flags_c (flags_c)
  );

  // Zero flag comes from the fresh result, never from the stale register.
  always_ff @(posedge clk) begin
    if (rst) begin
      out       <= '0;
      isZero    <= 1'b1;
      carry     <= 1'b0;
      overflow  <= 1'b0;
      negative  <= 1'b0;
      out_valid <= 1'b0;
    end else if (in_valid) begin
      out       <= result_c;
      isZero    <= flags_c.zero;
      carry     <= flags_c.carry;
      overflow  <= flags_c.overflow;
      negative  <= flags_c.negative;
      out_valid <= 1'b1;
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_unit.sv
// Scoreboard bench for alu_unit: directed vectors, queued expectations, negedge monitor.
module tb_alu_unit;

  localparam int unsigned WIDTH = 8;

  logic             clk;
  logic             rst;
  logic [1:0]       ALU_Op;
  logic [WIDTH-1:0] inA;
  logic [WIDTH-1:0] inB;
  logic             in_valid;
  logic [WIDTH-1:0] out;
  logic             isZero;
  logic             carry;
  logic             overflow;
  logic             negative;
  logic             out_valid;

  // Packed as {out, zero, carry, overflow, negative}.
  typedef logic [WIDTH+3:0] resp_t;

  typedef struct {
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
    resp_t      exp;
  } vec_t;

  resp_t queueExp[$];
  int    checks   = 0;
  int    failures = 0;
  int    pops     = 0;

  alu_unit #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .ALU_Op   (ALU_Op),
    .inA      (inA),
    .inB      (inB),
    .in_valid (in_valid),
    .out      (out),
    .isZero   (isZero),
    .carry    (carry),
    .overflow (overflow),
    .negative (negative),
    .out_valid(out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic resp_t mk(input logic [7:0] o, input logic z, input logic c,
                               input logic v, input logic n);
    return {o, z, c, v, n};
  endfunction

  // Monitor: every valid output must match the oldest queued expectation.
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (queueExp.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result: got 0x%0h with no pending expectation", out);
      end else begin
        resp_t e;
        e = queueExp.pop_front();
        pops++;
        check($sformatf("result_%0d", pops), 32'({out, isZero, carry, overflow, negative}), 32'(e));
      end
    end
  end

  task automatic issue(input vec_t v);
    ALU_Op   = v.op;
    inA      = v.a;
    inB      = v.b;
    in_valid = 1'b1;
    queueExp.push_back(v.exp);
    @(posedge clk);
    #1;
    check("out_valid_high", 32'(out_valid), 32'd1);
  endtask

  vec_t vecs[$];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // op, a, b, {out, zero, carry, overflow, negative}
    vecs.push_back('{2'b00, 8'd10,  8'd20,  mk(8'h1E, 0, 0, 0, 0)});
    vecs.push_back('{2'b00, 8'hFF,  8'h01,  mk(8'h00, 1, 1, 0, 0)});
    vecs.push_back('{2'b00, 8'h7F,  8'h01,  mk(8'h80, 0, 0, 1, 1)});
    vecs.push_back('{2'b01, 8'd30,  8'd30,  mk(8'h00, 1, 0, 0, 0)});
    vecs.push_back('{2'b01, 8'h05,  8'h06,  mk(8'hFF, 0, 1, 0, 1)});
    vecs.push_back('{2'b01, 8'h80,  8'h01,  mk(8'h7F, 0, 0, 1, 0)});
    vecs.push_back('{2'b10, 8'hCC,  8'hAA,  mk(8'h88, 0, 0, 0, 1)});
    vecs.push_back('{2'b11, 8'hCC,  8'hAA,  mk(8'hEE, 0, 0, 0, 1)});
    vecs.push_back('{2'b10, 8'hF0,  8'h0F,  mk(8'h00, 1, 0, 0, 0)});
    vecs.push_back('{2'b00, 8'h40,  8'h40,  mk(8'h80, 0, 0, 1, 1)});
    vecs.push_back('{2'b01, 8'h00,  8'h01,  mk(8'hFF, 0, 1, 0, 1)});
    vecs.push_back('{2'b11, 8'h00,  8'h00,  mk(8'h00, 1, 0, 0, 0)});
    vecs.push_back('{2'b00, 8'h80,  8'h80,  mk(8'h00, 1, 1, 1, 0)});

    // Reset held two cycles with a valid op presented.
    rst = 1'b1; in_valid = 1'b1; ALU_Op = 2'b00; inA = 8'd10; inB = 8'd20;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 32'({out, isZero, carry, overflow, negative, out_valid}),
          32'({8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}));
    rst = 1'b0;

    // Back-to-back stream, one op per cycle.
    foreach (vecs[i]) issue(vecs[i]);

    // Idle: last result (0x80+0x80) and its flags must hold.
    in_valid = 1'b0; ALU_Op = 2'b11; inA = 8'h5A; inB = 8'hA5;
    @(posedge clk);
    #1;
    check("hold_state", 32'({out, isZero, carry, overflow, negative, out_valid}),
          32'({8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}));
    @(posedge clk);
    #1;
    check("hold_state_2", 32'({out, carry, overflow, out_valid}),
          32'({8'h00, 1'b1, 1'b1, 1'b0}));

    // Mid-stream reset right after an ADD producing 0x1E.
    issue('{2'b00, 8'd10, 8'd20, mk(8'h1E, 0, 0, 0, 0)});
    rst = 1'b1; in_valid = 1'b1; ALU_Op = 2'b00; inA = 8'hFF; inB = 8'h01;
    @(posedge clk);
    #1;
    check("midstream_reset", 32'({out, isZero, carry, overflow, negative, out_valid}),
          32'({8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}));
    rst = 1'b0; in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    check("queue_drained", 32'(queueExp.size()), 32'd0);
    check("results_seen", 32'(pops), 32'(vecs.size() + 1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
